// File: rtl/i2c_config_sequencer_if.sv
// Bus between the configuration sequencer, its table ROM and the I2C
// byte-write controller. The sequencer drives the master side; the ROM and
// the controller together form the slave side.
interface i2c_config_sequencer_if;
    logic [5:0]  LUT_INDEX;   // table address, sequencer -> ROM
    logic [23:0] LUT_DATA;    // {sub_addr, data} for LUT_INDEX, ROM -> sequencer
    logic [31:0] I2C_DATA;    // {slave addr, sub_addr, data}, sequencer -> controller
    logic        GO;          // level-held transfer request
    logic        END;         // controller idle/complete; low while a transfer runs
    logic        ACK;         // 1 = slave did not acknowledge

    modport master (
        output LUT_INDEX,
        output I2C_DATA,
        output GO,
        input  LUT_DATA,
        input  END,
        input  ACK
    );

    modport slave (
        input  LUT_INDEX,
        input  I2C_DATA,
        input  GO,
        output LUT_DATA,
        output END,
        output ACK
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// I2C configuration sequencer: walks a register-write table once per START
// pulse, hands each entry to an external I2C controller with a GO/END
// handshake, checks the slave acknowledge, and reports DONE or ERROR.
//
// Optional feature: define I2C_SEQ_RETRY_EN to retry a NACKed entry up to
// MAX_RETRY times before giving up. Without it, any NACK is fatal and no
// retry counter exists.
module i2c_config_sequencer #(
    parameter int         LUT_SIZE   = 16,
    parameter logic [7:0] SLAVE_ADDR = 8'h34,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 63
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   START,
    i2c_config_sequencer_if.master bus,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERROR,
    output logic [5:0]             ERR_INDEX
);

    // Watchdog counts 0..TIMEOUT-1, gap counter 0..GAP_CYCLES-1.
    localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [5:0]       LAST_IDX = 6'(LUT_SIZE - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        CHECK,
        GAP,
        FIN,
        FAIL
    } state_t;

    state_t            state_q;
    logic [5:0]        lut_index_q;
    logic [5:0]        lut_index_d;
    logic [31:0]       i2c_data_q;
    logic              go_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [5:0]        err_index_q;
    logic [WD_W-1:0]   wd_q;
    logic [GAP_W-1:0]  gap_q;
    logic              adv_q;      // current entry was ACKed; advance after the gap
    logic              is_last;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retry_q;
    logic               new_idx_q;  // next LOAD fetches a fresh index, so clear retries
`endif

    // Next table index saturates at the last entry so the address never wraps.
    assign is_last     = (lut_index_q == LAST_IDX);
    assign lut_index_d = is_last ? lut_index_q : lut_index_q + 6'd1;

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            lut_index_q <= 6'd0;
            i2c_data_q  <= 32'd0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= 6'd0;
            wd_q        <= '0;
            gap_q       <= '0;
            adv_q       <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= '0;
            new_idx_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                // A START in any resting state begins a full run from entry 0.
                IDLE, FIN, FAIL: begin
                    if (START) begin
                        lut_index_q <= 6'd0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        adv_q       <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
                        new_idx_q   <= 1'b1;
`endif
                        state_q     <= LOAD;
                    end
                end

                // Capture the table word; it stays frozen until the next LOAD.
                LOAD: begin
                    i2c_data_q <= {SLAVE_ADDR, bus.LUT_DATA};
`ifdef I2C_SEQ_RETRY_EN
                    if (new_idx_q) begin
                        retry_q <= '0;
                    end
                    new_idx_q <= 1'b0;
`endif
                    state_q <= ISSUE;
                end

                ISSUE: begin
                    go_q    <= 1'b1;
                    wd_q    <= '0;
                    state_q <= WAIT_LO;
                end

                // Controller has not started yet; END falls when it does.
                WAIT_LO: begin
                    if (wd_q == WD_LAST) begin
                        go_q        <= 1'b0;
                        busy_q      <= 1'b0;
                        error_q     <= 1'b1;
                        err_index_q <= lut_index_q;
                        state_q     <= FAIL;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                        if (!bus.END) begin
                            state_q <= WAIT_HI;
                        end
                    end
                end

                // Transfer running; a completion seen on the last allowed
                // cycle still counts as in time.
                WAIT_HI: begin
                    if (bus.END) begin
                        go_q    <= 1'b0;
                        state_q <= CHECK;
                    end else if (wd_q == WD_LAST) begin
                        go_q        <= 1'b0;
                        busy_q      <= 1'b0;
                        error_q     <= 1'b1;
                        err_index_q <= lut_index_q;
                        state_q     <= FAIL;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end

                // ACK is sampled one cycle after END rose.
                CHECK: begin
                    gap_q <= '0;
                    if (!bus.ACK) begin
                        adv_q   <= 1'b1;
                        state_q <= GAP;
                    end else begin
`ifdef I2C_SEQ_RETRY_EN
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            adv_q   <= 1'b0;
                            state_q <= GAP;
                        end else begin
                            busy_q      <= 1'b0;
                            error_q     <= 1'b1;
                            err_index_q <= lut_index_q;
                            state_q     <= FAIL;
                        end
`else
                        busy_q      <= 1'b0;
                        error_q     <= 1'b1;
                        err_index_q <= lut_index_q;
                        state_q     <= FAIL;
`endif
                    end
                end

                // Idle spacing between transfers, then next entry, retry or finish.
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (adv_q) begin
                            adv_q <= 1'b0;
                            if (is_last) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= FIN;
                            end else begin
                                lut_index_q <= lut_index_d;
`ifdef I2C_SEQ_RETRY_EN
                                new_idx_q   <= 1'b1;
`endif
                                state_q     <= LOAD;
                            end
                        end else begin
                            state_q <= LOAD;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end

                default: begin
                    go_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.LUT_INDEX = lut_index_q;
    assign bus.I2C_DATA  = i2c_data_q;
    assign bus.GO        = go_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERROR         = error_q;
    assign ERR_INDEX     = err_index_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench for i2c_config_sequencer: a table model predicts the
// sequence of GO transfers and the final status of each run; a monitor
// compares what the DUT presents against that queue.
`timescale 1ns/1ps
module tb_i2c_config_sequencer;

    localparam int LUT_SIZE   = 4;
    localparam int MAX_RETRY  = 3;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 63;
    localparam logic [7:0] SLAVE_ADDR = 8'h34;
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [5:0] err_index;

    i2c_config_sequencer_if bus();

    logic [23:0] lut_mem [64];
    assign bus.LUT_DATA = lut_mem[bus.LUT_INDEX];

    i2c_config_sequencer #(
        .LUT_SIZE  (LUT_SIZE),
        .SLAVE_ADDR(SLAVE_ADDR),
        .MAX_RETRY (MAX_RETRY),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLOCK    (clk),
        .RESET    (rst),
        .START    (start),
        .bus      (bus),
        .BUSY     (busy),
        .DONE     (done),
        .ERROR    (error),
        .ERR_INDEX(err_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_status;
        logic [31:0] data;
        logic [5:0]  idx;
        bit          done;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   nack_cnt [LUT_SIZE];   // NACKs the slave gives an entry before ACKing
    int   tries    [LUT_SIZE];
    bit   stuck_mode = 1'b0;
    int   hold_extra = 0;
    int   last_go_len = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void push_go(input int i);
        exp_t e;
        e.is_status = 1'b0;
        e.data      = {SLAVE_ADDR, lut_mem[i]};
        e.idx       = 6'(i);
        e.done      = 1'b0;
        e.err       = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_status(input bit d, input bit er, input int i);
        exp_t e;
        e.is_status = 1'b1;
        e.data      = 32'h0;
        e.idx       = 6'(i);
        e.done      = d;
        e.err       = er;
        exp_q.push_back(e);
    endfunction

    // Reference: each entry is tried until ACKed or the retry allowance is spent.
    function automatic void model_run();
        for (int i = 0; i < LUT_SIZE; i++) begin
            int  attempts;
            bit  fails;
            if (RETRY_EN) begin
                fails    = nack_cnt[i] > MAX_RETRY;
                attempts = fails ? MAX_RETRY + 1 : nack_cnt[i] + 1;
            end else begin
                fails    = nack_cnt[i] > 0;
                attempts = 1;
            end
            for (int a = 0; a < attempts; a++) push_go(i);
            if (fails) begin
                push_status(1'b0, 1'b1, i);
                return;
            end
        end
        push_status(1'b1, 1'b0, 0);
    endfunction

    // Behavioural I2C controller: answers GO with an END low pulse and an ACK flag.
    initial begin : ctrl
        int idx;
        int d1;
        int d2;
        bit nack;
        bus.END = 1'b1;
        bus.ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.GO === 1'b1 && !stuck_mode && rst === 1'b0) begin
                idx  = int'(bus.LUT_INDEX);
                nack = 1'b0;
                if (idx < LUT_SIZE) begin
                    nack = (tries[idx] < nack_cnt[idx]);
                    tries[idx]++;
                end
                d1 = int'($urandom_range(3, 0));
                d2 = int'($urandom_range(6, 1));
                repeat (d1) @(negedge clk);
                bus.END = 1'b0;
                repeat (d2 + hold_extra) @(negedge clk);
                bus.ACK = nack;
                bus.END = 1'b1;
                for (int k = 0; k < 8 && bus.GO === 1'b1; k++) @(negedge clk);
            end
        end
    end

    // Monitor: pops the scoreboard on each GO rise and on each BUSY fall.
    initial begin : mon
        logic        prev_go;
        logic        prev_busy;
        int          high_len;
        int          low_len;
        bit          fall_in_run;
        bit          stable;
        logic [31:0] held;
        exp_t        e;
        prev_go = 1'b0; prev_busy = 1'b0; high_len = 0; low_len = 0;
        fall_in_run = 1'b0; stable = 1'b1; held = 32'h0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_go = 1'b0; prev_busy = 1'b0; fall_in_run = 1'b0;
                high_len = 0; low_len = 0;
            end else begin
                if (bus.GO === 1'b1 && !prev_go) begin
                    // Low time between transfers: CHECK, GAP_CYCLES of GAP, LOAD, ISSUE.
                    if (fall_in_run) chk("go_low_gap", 32'(low_len), 32'(GAP_CYCLES + 3));
                    if (exp_q.size() == 0 || exp_q[0].is_status) begin
                        checks++; errors++;
                        $display("FAIL unexpected_go actual_index=%0d actual_data=%h required=none", bus.LUT_INDEX, bus.I2C_DATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("i2c_data", bus.I2C_DATA, e.data);
                        chk("lut_index", 32'(bus.LUT_INDEX), 32'(e.idx));
                        $display("go   idx=%0d data=%h", bus.LUT_INDEX, bus.I2C_DATA);
                    end
                    held = bus.I2C_DATA; stable = 1'b1; high_len = 0;
                end
                if (bus.GO !== 1'b1 && prev_go) begin
                    chk("data_stable", 32'(stable), 32'd1);
                    last_go_len = high_len; low_len = 0; fall_in_run = 1'b1;
                end
                if (bus.GO === 1'b1) begin
                    high_len++;
                    if (bus.I2C_DATA !== held) stable = 1'b0;
                end else begin
                    low_len++;
                end
                if (busy !== 1'b1 && prev_busy) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_status) begin
                        checks++; errors++;
                        $display("FAIL unexpected_end actual_done=%0d actual_error=%0d required=more_transfers", done, error);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done", 32'(done), 32'(e.done));
                        chk("error", 32'(error), 32'(e.err));
                        if (e.err) chk("err_index", 32'(err_index), 32'(e.idx));
                        $display("end  done=%0d error=%0d err_index=%0d", done, error, err_index);
                    end
                end
                if (busy !== 1'b1) fall_in_run = 1'b0;
                prev_go   = (bus.GO === 1'b1);
                prev_busy = (busy === 1'b1);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic run_table(input string name, input bit poke);
        for (int i = 0; i < LUT_SIZE; i++) tries[i] = 0;
        model_run();
        pulse_start();
        if (poke) begin
            // Extra STARTs early in the run, well before it can finish.
            foreach (tries[i]) begin
                repeat (4) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_drain(name);
    endtask

    initial begin : global_bound
        #800000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation bound reached");
    end

    initial begin : main
        int n;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) lut_mem[i] = 24'($urandom);
        for (int i = 0; i < LUT_SIZE; i++) begin nack_cnt[i] = 0; tries[i] = 0; end
        repeat (3) @(negedge clk);

        chk("rst_go", 32'(bus.GO), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_lut_index", 32'(bus.LUT_INDEX), 32'd0);
        chk("rst_i2c_data", bus.I2C_DATA, 32'd0);
        chk("rst_err_index", 32'(err_index), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // RESET and START together: reset wins, nothing starts.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);

        // All entries ACKed.
        run_table("all_ack", 1'b0);
        chk("final_lut_index", 32'(bus.LUT_INDEX), 32'(LUT_SIZE - 1));
        chk("final_busy", 32'(busy), 32'd0);

        // Entry 2 never acknowledged.
        nack_cnt[2] = 1000;
        run_table("nack_idx2", 1'b0);
        nack_cnt[2] = 0;

        // Recoverable NACKs on two entries.
        nack_cnt[1] = 2; nack_cnt[3] = 1;
        run_table("retry_mix", 1'b0);
        nack_cnt[1] = 0; nack_cnt[3] = 0;

        // Controller stuck with END high: watchdog ends the run on entry 0.
        stuck_mode = 1'b1;
        push_go(0);
        push_status(1'b0, 1'b1, 0);
        pulse_start();
        wait_drain("stuck");
        chk("timeout_go_len", 32'(last_go_len), 32'(TIMEOUT));
        stuck_mode = 1'b0;

        // Reset while entry 1 is in flight, then a clean full run.
        hold_extra = 6;
        for (int i = 0; i < LUT_SIZE; i++) tries[i] = 0;
        model_run();
        pulse_start();
        n = 0;
        while (!(bus.GO === 1'b1 && bus.LUT_INDEX == 6'd1 && bus.END === 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx1_transfer", 32'(n < 3000), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_go", 32'(bus.GO), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_lut_index", 32'(bus.LUT_INDEX), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        hold_extra = 0;
        repeat (30) @(negedge clk);
        run_table("after_reset", 1'b0);

        // START pulses while busy have no effect.
        run_table("start_while_busy", 1'b1);

        // Randomised tables and NACK patterns.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < LUT_SIZE; i++) begin
                lut_mem[i]  = 24'($urandom);
                nack_cnt[i] = ($urandom_range(9, 0) < 7) ? 0 : int'($urandom_range(5, 1));
            end
            run_table("random", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
